ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
Shares the single data-path RAM port between two requesters: instruction fetch (IF) and the load/store unit (LS). It uses round-robin arbitration and a req/ack handshake. It also sequences each granted access through the RAM's fixed read latency and returns read data to the winning requester. It sits between decode_fsm/data_path and the RAM, and replaces their direct en/we drive.

Parameters:
ADDR_W, 10, RAM word-address width
DATA_W, 16, RAM data width
RD_LAT, 1, RAM read latency in cycles from the ram_en cycle to valid ram_rdata; legal range 1..3

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; read only
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle pulse; fetch access complete
if_rdata  out  DATA_W  fetch read data; valid with if_ack, held until the next if_ack
ls_req  in  1  load/store request
ls_we  in  1  1 = write, 0 = read
ls_addr  in  ADDR_W  load/store address
ls_wdata  in  DATA_W  store data
ls_ack  out  1  one-cycle pulse; load/store access complete
ls_rdata  out  DATA_W  load data; valid with ls_ack, held until the next ls_ack
ram_en  out  1  RAM port enable
ram_we  out  1  RAM write enable; only ever high when ram_en is high
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data
busy  out  1  high when state != IDLE
last_grant  out  1  0 = IF was granted last, 1 = LS was granted last

Behaviour:
- Reset:
  - All outputs 0, except last_grant = 1, so IF wins the first tie.
  - State goes to IDLE; wait counter cleared.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - Samples if_req and ls_req every cycle.
  - Neither high: stay in IDLE.
  - Exactly one high: grant that requester.
  - Both high: grant the requester opposite to last_grant.
  - On grant: capture the winner's addr, we (IF forced to 0) and wdata; update last_grant; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - ram_en = 1, ram_we = captured we, ram_addr and ram_wdata from the captured values.
  - Write: next state DONE.
  - Read: load counter with RD_LAT; next state WAIT.
- WAIT:
  - ram_en = 0; counter decrements each cycle.
  - ram_rdata is valid in the cycle the counter reaches 1. It is captured at the end of that cycle into the winner's rdata register; next state DONE.
- DONE (exactly 1 cycle):
  - Winner's ack = 1; next state IDLE.
  - The loser's ack and rdata are unchanged.
- Latency, with the request sampled in IDLE cycle T0:
  - Write: ram_we pulses in T1; ack in T2.
  - Read: ram_en in T1; ack in T(2+RD_LAT).
  - Minimum spacing between consecutive grants: write 3 cycles, read RD_LAT+3 cycles.
- Handshake:
  - A requester holds req, addr, we and wdata stable until its ack.
  - It drops req on the edge after ack.
  - req still high in the IDLE cycle after DONE is a new request; it is not an error.
  - req falling before ack is illegal; the arbiter still completes the captured access and pulses ack.
  - Input changes after grant have no effect on the in-flight access.
- No starvation: with both requesters held high, grants strictly alternate IF, LS, IF, …
- ram_addr and ram_wdata hold their last value outside ISSUE. ram_we is 0 outside ISSUE.
- Reset mid-operation (any state):
  - Next cycle is IDLE.
  - In-flight access is dropped: no ack, ram_en = 0, rdata registers cleared to 0, last_grant = 1.
- Out-of-range RD_LAT is a parameter error; the block must not silently clamp it.

Test Plan:
1. RAM[0x010] = 0x5105, RD_LAT = 1; if_req with if_addr = 0x010 at T0 -> ram_en = 1 and ram_addr = 0x010 in T1; if_ack pulses in T3 with if_rdata = 0x5105; busy high T1..T3.
2. LS write: ls_we = 1, ls_addr = 0x020, ls_wdata = 0xBEEF -> ram_we pulse in T1 only; ls_ack in T2. Then an LS read of 0x020 -> ls_rdata = 0xBEEF with ls_ack.
3. After reset, if_req and ls_req both held high continuously -> grant order IF, LS, IF, LS; last_grant toggles 0, 1, 0, 1; each ack is a single-cycle pulse.
4. Reset asserted during WAIT (RD_LAT = 3) -> no ack; outputs return to reset values the next cycle; the next IF request completes normally.
5. RD_LAT = 3, IF read of RAM[0x001] = 0x021D -> if_ack in T5 with if_rdata = 0x021D; ram_en high only in T1.
6. LS read completes with ls_rdata = 0x1234 while IF stays idle -> if_rdata and if_ack remain unchanged.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin IF/LS arbiter sequencing a fixed-latency RAM port
module ram_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              last_grant
);

    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
        $error("ram_port_arbiter: RD_LAT must be in 1..3");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                owner_q, owner_d;   // 0 = IF, 1 = LS
    logic                we_q, we_d;
    logic                grant, grant_ls, capture;

    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                if_ack_q, if_ack_d;
    logic                ls_ack_q, ls_ack_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
    logic                busy_q, busy_d;
    logic                last_grant_q, last_grant_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            if_ack_q     <= 1'b0;
            ls_ack_q     <= 1'b0;
            if_rdata_q   <= '0;
            ls_rdata_q   <= '0;
            busy_q       <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            if_ack_q     <= if_ack_d;
            ls_ack_q     <= ls_ack_d;
            if_rdata_q   <= if_rdata_d;
            ls_rdata_q   <= ls_rdata_d;
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
        end
    end

    // On a tie the winner is the requester that was not granted last.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant    = 1'b0;
        grant_ls = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (if_req || ls_req) begin
                    grant    = 1'b1;
                    grant_ls = ls_req && (!if_req || !last_grant_q);
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = 2'(RD_LAT);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so their next values are derived from the upcoming state.
    always_comb begin
        capture      = (state_q == S_WAIT) && (cnt_q == 2'd1);
        owner_d      = grant ? grant_ls : owner_q;
        we_d         = grant ? (grant_ls && ls_we) : we_q;
        last_grant_d = grant ? grant_ls : last_grant_q;
        ram_en_d     = grant;
        ram_we_d     = grant && grant_ls && ls_we;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        if (grant) begin
            ram_addr_d = grant_ls ? ls_addr : if_addr;
            if (grant_ls) begin
                ram_wdata_d = ls_wdata;
            end
        end
        if_ack_d   = (state_d == S_DONE) && !owner_q;
        ls_ack_d   = (state_d == S_DONE) && owner_q;
        if_rdata_d = (capture && !owner_q) ? ram_rdata : if_rdata_q;
        ls_rdata_d = (capture && owner_q) ? ram_rdata : ls_rdata_q;
        busy_d     = (state_d != S_IDLE);
    end

    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign if_ack     = if_ack_q;
    assign ls_ack     = ls_ack_q;
    assign if_rdata   = if_rdata_q;
    assign ls_rdata   = ls_rdata_q;
    assign busy       = busy_q;
    assign last_grant = last_grant_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter at RD_LAT 1 and 3
module tb_ram_port_arbiter;

    typedef struct {
        bit          ls;
        logic [15:0] data;
        logic [31:0] ack_m;
    } exp_t;

    logic        clk;
    logic        reset      [2];
    logic        if_req     [2];
    logic [9:0]  if_addr    [2];
    logic        if_ack     [2];
    logic [15:0] if_rdata   [2];
    logic        ls_req     [2];
    logic        ls_we      [2];
    logic [9:0]  ls_addr    [2];
    logic [15:0] ls_wdata   [2];
    logic        ls_ack     [2];
    logic [15:0] ls_rdata   [2];
    logic        ram_en     [2];
    logic        ram_we     [2];
    logic [9:0]  ram_addr   [2];
    logic [15:0] ram_wdata  [2];
    logic [15:0] ram_rdata  [2];
    logic        busy       [2];
    logic        last_grant [2];

    logic [15:0] mem  [2][1024];
    logic [15:0] pipe [2][3];

    int   checks;
    int   failures;
    exp_t sb[$];

    ram_port_arbiter #(.ADDR_W(10), .DATA_W(16), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset[0]),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
        .ls_req(ls_req[0]), .ls_we(ls_we[0]), .ls_addr(ls_addr[0]), .ls_wdata(ls_wdata[0]),
        .ls_ack(ls_ack[0]), .ls_rdata(ls_rdata[0]),
        .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
        .ram_rdata(ram_rdata[0]), .busy(busy[0]), .last_grant(last_grant[0])
    );

    ram_port_arbiter #(.ADDR_W(10), .DATA_W(16), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset[1]),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
        .ls_req(ls_req[1]), .ls_we(ls_we[1]), .ls_addr(ls_addr[1]), .ls_wdata(ls_wdata[1]),
        .ls_ack(ls_ack[1]), .ls_rdata(ls_rdata[1]),
        .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
        .ram_rdata(ram_rdata[1]), .busy(busy[1]), .last_grant(last_grant[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: contents preloaded while the matching reset is high; reads return
    // data RD_LAT cycles after the enable cycle, 16'hDEAD otherwise.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset[k]) begin
                if (k == 0) begin
                    mem[k][10'h010] <= 16'h5105;
                    mem[k][10'h030] <= 16'h1234;
                end else begin
                    mem[k][10'h001] <= 16'h021D;
                    mem[k][10'h002] <= 16'h0F0F;
                end
            end else if (ram_en[k] && ram_we[k]) begin
                mem[k][ram_addr[k]] <= ram_wdata[k];
            end
            pipe[k][0] <= (ram_en[k] && !ram_we[k]) ? mem[k][ram_addr[k]] : 16'hDEAD;
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
        end
    end
    assign ram_rdata[0] = pipe[0][0];
    assign ram_rdata[1] = pipe[1][2];

    function automatic logic [63:0] snap(input int k);
        return {if_ack[k], if_rdata[k], ls_ack[k], ls_rdata[k], ram_en[k], ram_we[k],
                ram_addr[k], ram_wdata[k], busy[k], last_grant[k]};
    endfunction

    // Issues one request at the current negedge (cycle T0) and records outputs for T1..T15.
    task automatic access(input int k, input bit ls, input bit we, input logic [9:0] addr,
                          input logic [15:0] wd, output logic [31:0] en_m, output logic [31:0] we_m,
                          output logic [31:0] busy_m, output logic [31:0] ack_m,
                          output logic [31:0] oack_m, output logic [15:0] rd, output logic [9:0] a1);
        logic ack, oack;
        en_m = '0; we_m = '0; busy_m = '0; ack_m = '0; oack_m = '0; rd = '0; a1 = '0;
        if (ls) begin
            ls_req[k] = 1'b1; ls_we[k] = we; ls_addr[k] = addr; ls_wdata[k] = wd;
        end else begin
            if_req[k] = 1'b1; if_addr[k] = addr;
        end
        for (int t = 1; t <= 15; t++) begin
            @(negedge clk);
            en_m[t]   = ram_en[k];
            we_m[t]   = ram_we[k];
            busy_m[t] = busy[k];
            if (t == 1) a1 = ram_addr[k];
            ack  = ls ? ls_ack[k] : if_ack[k];
            oack = ls ? if_ack[k] : ls_ack[k];
            oack_m[t] = oack;
            if (ack) begin
                ack_m[t] = 1'b1;
                rd = ls ? ls_rdata[k] : if_rdata[k];
                if (ls) ls_req[k] = 1'b0; else if_req[k] = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        reset[0] = 1'b1; reset[1] = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (snap(k) !== 64'h1) begin
                failures++;
                $display("FAIL reset_state[%0d]: got %h expected %h", k, snap(k), 64'h1);
            end
        end
        reset[0] = 1'b0; reset[1] = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (snap(k) !== 64'h1) begin
                failures++;
                $display("FAIL idle_after_reset[%0d]: got %h expected %h", k, snap(k), 64'h1);
            end
        end
    endtask

    task automatic test_if_read;
        logic [31:0] en_m, we_m, busy_m, ack_m, oack_m;
        logic [15:0] rd;
        logic [9:0]  a1;
        exp_t e;
        sb.push_back('{ls: 1'b0, data: 16'h5105, ack_m: 32'h8});
        access(0, 1'b0, 1'b0, 10'h010, 16'h0, en_m, we_m, busy_m, ack_m, oack_m, rd, a1);
        e = sb.pop_front();
        checks++;
        if (en_m !== 32'h2 || a1 !== 10'h010) begin
            failures++;
            $display("FAIL if_read_issue: en_mask %h addr %h expected en_mask 00000002 addr 010", en_m, a1);
        end
        checks++;
        if (ack_m !== e.ack_m) begin
            failures++;
            $display("FAIL if_read_ack: mask %h expected %h", ack_m, e.ack_m);
        end
        checks++;
        if (rd !== e.data) begin
            failures++;
            $display("FAIL if_read_data: got %h expected %h", rd, e.data);
        end
        checks++;
        if (busy_m !== 32'hE || we_m !== 32'h0) begin
            failures++;
            $display("FAIL if_read_busy: busy %h we %h expected busy 0000000e we 00000000", busy_m, we_m);
        end
    endtask

    task automatic test_ls_write_read;
        logic [31:0] en_m, we_m, busy_m, ack_m, oack_m;
        logic [15:0] rd;
        logic [9:0]  a1;
        exp_t e;
        sb.push_back('{ls: 1'b1, data: 16'h0, ack_m: 32'h4});
        access(0, 1'b1, 1'b1, 10'h020, 16'hBEEF, en_m, we_m, busy_m, ack_m, oack_m, rd, a1);
        e = sb.pop_front();
        checks++;
        if (we_m !== 32'h2 || en_m !== 32'h2 || a1 !== 10'h020) begin
            failures++;
            $display("FAIL ls_write_pulse: we %h en %h addr %h expected we 00000002 en 00000002 addr 020",
                     we_m, en_m, a1);
        end
        checks++;
        if (ack_m !== e.ack_m || busy_m !== 32'h6) begin
            failures++;
            $display("FAIL ls_write_ack: ack %h busy %h expected ack %h busy 00000006", ack_m, busy_m, e.ack_m);
        end
        sb.push_back('{ls: 1'b1, data: 16'hBEEF, ack_m: 32'h8});
        access(0, 1'b1, 1'b0, 10'h020, 16'h0, en_m, we_m, busy_m, ack_m, oack_m, rd, a1);
        e = sb.pop_front();
        checks++;
        if (ack_m !== e.ack_m || rd !== e.data) begin
            failures++;
            $display("FAIL ls_readback: ack %h data %h expected ack %h data %h", ack_m, rd, e.ack_m, e.data);
        end
    endtask

    task automatic test_ls_isolation;
        logic [31:0] en_m, we_m, busy_m, ack_m, oack_m;
        logic [15:0] rd;
        logic [9:0]  a1;
        exp_t e;
        sb.push_back('{ls: 1'b1, data: 16'h1234, ack_m: 32'h8});
        access(0, 1'b1, 1'b0, 10'h030, 16'h0, en_m, we_m, busy_m, ack_m, oack_m, rd, a1);
        e = sb.pop_front();
        checks++;
        if (ack_m !== e.ack_m || rd !== e.data) begin
            failures++;
            $display("FAIL ls_read: ack %h data %h expected ack %h data %h", ack_m, rd, e.ack_m, e.data);
        end
        checks++;
        if (oack_m !== 32'h0 || if_rdata[0] !== 16'h5105) begin
            failures++;
            $display("FAIL if_untouched: if_ack mask %h if_rdata %h expected 00000000 5105", oack_m, if_rdata[0]);
        end
        checks++;
        if (last_grant[0] !== 1'b1) begin
            failures++;
            $display("FAIL last_grant_ls: got %b expected 1", last_grant[0]);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] if_m, ls_m, lg_m;
        exp_t e;
        bit   port;
        logic [15:0] d;
        if_m = '0; ls_m = '0; lg_m = '0;
        reset[0] = 1'b1;
        @(negedge clk);
        reset[0] = 1'b0;
        sb.push_back('{ls: 1'b0, data: 16'h5105, ack_m: 32'h0});
        sb.push_back('{ls: 1'b1, data: 16'h1234, ack_m: 32'h0});
        sb.push_back('{ls: 1'b0, data: 16'h5105, ack_m: 32'h0});
        sb.push_back('{ls: 1'b1, data: 16'h1234, ack_m: 32'h0});
        if_req[0] = 1'b1; if_addr[0] = 10'h010;
        ls_req[0] = 1'b1; ls_we[0] = 1'b0; ls_addr[0] = 10'h030;
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            if_m[t] = if_ack[0];
            ls_m[t] = ls_ack[0];
            lg_m[t] = last_grant[0];
            if (if_ack[0] || ls_ack[0]) begin
                port = ls_ack[0];
                d    = port ? ls_rdata[0] : if_rdata[0];
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL rr_extra_ack: cycle %0d port %0d expected no ack", t, port);
                end else begin
                    e = sb.pop_front();
                    if ((if_ack[0] && ls_ack[0]) || port !== e.ls || d !== e.data) begin
                        failures++;
                        $display("FAIL rr_order: cycle %0d port %0d data %h expected port %0d data %h",
                                 t, port, d, e.ls, e.data);
                    end
                end
            end
        end
        if_req[0] = 1'b0; ls_req[0] = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL rr_missing_acks: %0d outstanding expected 0", sb.size());
            sb.delete();
        end
        checks++;
        if (if_m !== 32'h0808 || ls_m !== 32'h8080) begin
            failures++;
            $display("FAIL rr_ack_pulses: if %h ls %h expected if 00000808 ls 00008080", if_m, ls_m);
        end
        checks++;
        if (lg_m !== 32'h0001E1E0) begin
            failures++;
            $display("FAIL rr_last_grant: trace %h expected 0001e1e0", lg_m);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_rdlat3;
        logic [31:0] en_m, we_m, busy_m, ack_m, oack_m;
        logic [15:0] rd;
        logic [9:0]  a1;
        exp_t e;
        sb.push_back('{ls: 1'b0, data: 16'h021D, ack_m: 32'h20});
        access(1, 1'b0, 1'b0, 10'h001, 16'h0, en_m, we_m, busy_m, ack_m, oack_m, rd, a1);
        e = sb.pop_front();
        checks++;
        if (ack_m !== e.ack_m || rd !== e.data) begin
            failures++;
            $display("FAIL rdlat3_read: ack %h data %h expected ack %h data %h", ack_m, rd, e.ack_m, e.data);
        end
        checks++;
        if (en_m !== 32'h2 || busy_m !== 32'h3E) begin
            failures++;
            $display("FAIL rdlat3_timing: en %h busy %h expected en 00000002 busy 0000003e", en_m, busy_m);
        end
    endtask

    task automatic test_reset_in_wait;
        logic [31:0] en_m, we_m, busy_m, ack_m, oack_m;
        logic [15:0] rd;
        logic [9:0]  a1;
        int          acks;
        exp_t e;
        acks = 0;
        if_req[1] = 1'b1; if_addr[1] = 10'h001;
        repeat (3) @(negedge clk);
        checks++;
        if (busy[1] !== 1'b1 || ram_en[1] !== 1'b0 || if_rdata[1] !== 16'h021D) begin
            failures++;
            $display("FAIL wait_state: busy %b en %b if_rdata %h expected 1 0 021d", busy[1], ram_en[1], if_rdata[1]);
        end
        reset[1] = 1'b1;
        if_req[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (snap(1) !== 64'h1) begin
            failures++;
            $display("FAIL reset_in_wait: got %h expected %h", snap(1), 64'h1);
        end
        reset[1] = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (if_ack[1] || ls_ack[1] || busy[1]) acks++;
        end
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL dropped_access: %0d active cycles expected 0", acks);
        end
        sb.push_back('{ls: 1'b0, data: 16'h0F0F, ack_m: 32'h20});
        access(1, 1'b0, 1'b0, 10'h002, 16'h0, en_m, we_m, busy_m, ack_m, oack_m, rd, a1);
        e = sb.pop_front();
        checks++;
        if (ack_m !== e.ack_m || rd !== e.data || a1 !== 10'h002) begin
            failures++;
            $display("FAIL read_after_reset: ack %h data %h addr %h expected ack %h data %h addr 002",
                     ack_m, rd, a1, e.ack_m, e.data);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = '0;
            ls_req[k] = 1'b0; ls_we[k] = 1'b0; ls_addr[k] = '0; ls_wdata[k] = '0;
        end
        @(negedge clk);
        test_reset;
        test_if_read;
        test_ls_write_read;
        test_ls_isolation;
        test_back_to_back;
        test_rdlat3;
        test_reset_in_wait;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
